// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_OFF_W = 2;

    // Word index of a byte address (byte offset dropped, not yet wrapped).
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, combinational read.
// Not reset; contents survive responder resets.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_strb,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    // Commit each enabled byte lane; disabled lanes keep their old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, LATENCY wait cycles,
// then a word access answered over a valid/ready response channel.
// Optional macro MEM_RESPONDER_ERR_CHECK_EN flags misaligned and
// out-of-range requests instead of wrapping them.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_write;
    logic          cap_err;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;

    logic [31:0]   req_word;
    logic [AW-1:0] req_idx;
    logic          req_err;
    logic          unused_addr;

    logic          accept;
    logic          exec_now;
    logic          exec_wait;
    logic          acc_write;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic [31:0]   resp_rdata_nxt;

    assign req_word = word_index(req_addr);
    assign req_idx  = req_word[AW-1:0];

`ifdef MEM_RESPONDER_ERR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_word >= 32'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    assign unused_addr = ^{req_word[31:AW], req_addr[1:0]};

    // Select the request being executed: live inputs when LATENCY=0 executes
    // on the accept edge, otherwise the captured copy at the end of WAIT.
    always_comb begin
        accept    = (state == IDLE) && req_valid && req_ready;
        exec_now  = (LATENCY == 0) && accept;
        exec_wait = (state == WAIT) && (cnt == '0);
        if (exec_now) begin
            acc_write = req_write;
            acc_err   = req_err;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_write = cap_write;
            acc_err   = cap_err;
            acc_idx   = cap_idx;
            acc_wdata = cap_wdata;
            acc_wstrb = cap_wstrb;
        end
        mem_we         = reset && (exec_now || exec_wait) && acc_write && !acc_err;
        resp_rdata_nxt = (acc_write || acc_err) ? '0 : mem_rdata;
    end

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (acc_idx),
        .wr_data (acc_wdata),
        .wr_strb (acc_wstrb),
        .rd_addr (acc_idx),
        .rd_data (mem_rdata)
    );

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_err    <= 1'b0;
            cap_idx    <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write <= req_write;
                        cap_err   <= req_err;
                        cap_idx   <= req_idx;
                        cap_wdata <= req_wdata;
                        cap_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= resp_rdata_nxt;
                            resp_err   <= acc_err;
                            state      <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= resp_rdata_nxt;
                        resp_err   <= acc_err;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array model.
module tb_mem_responder #(
    parameter int unsigned LATENCY = 2
);

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WINDOW = 64;
`ifdef MEM_RESPONDER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          last_rise = 0;
    logic [31:0] last_rdata;
    logic [31:0] ref_mem [DEPTH];

    mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    // Reference behaviour: word array, byte lanes, optional rejection.
    task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        int unsigned idx;
        err   = ERR_EN && (((addr % 4) != 0) || ((addr / 4) >= DEPTH));
        idx   = (addr / 4) % DEPTH;
        rdata = '0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                rdata = ref_mem[idx];
            end
        end
    endtask

    // One full transaction; called at #1 after a rising edge.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int unsigned stall);
        int          n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        model_access(wr, addr, wdata, strb, exp_rdata, exp_err);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check_eq("latency", n, LATENCY);
        last_rise  = cycle;
        last_rdata = resp_rdata;
        check_eq("rdata", resp_rdata, exp_rdata);
        check_eq("err", resp_err, exp_err);
        check_eq("req_ready_busy", req_ready, 1'b0);
        for (int unsigned s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", resp_valid, 1'b1);
            check_eq("stall_rdata", resp_rdata, exp_rdata);
            check_eq("stall_err", resp_err, exp_err);
            check_eq("stall_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq("post_valid", resp_valid, 1'b0);
        check_eq("post_rdata", resp_rdata, 32'h0);
        check_eq("post_err", resp_err, 1'b0);
        check_eq("post_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] junk;
        logic        jerr;
        int          prev;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_err", resp_err, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int unsigned k = 0; k < WINDOW; k++) begin
            do_txn(1'b1, k * 4, $urandom, 4'hF, 0);
        end

        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check_eq("plan_deadbeef", last_rdata, 32'hDEADBEEF);
        do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
        check_eq("plan_bytes", last_rdata, 32'h11BB33DD);
        do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 5);
        check_eq("plan_nostrobe", last_rdata, 32'h11BB33DD);
        do_txn(1'b0, 32'h13, 32'h0, 4'h0, 0);
        do_txn(1'b1, 4 * DEPTH, 32'h5A5A5A5A, 4'hF, 0);
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0);

        // Back-to-back loads: response rises every LATENCY+2 cycles.
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            prev = last_rise;
            do_txn(1'b0, 32'(($urandom % WINDOW) * 4), 32'h0, 4'h0, 0);
            check_eq("b2b_period", last_rise - prev, LATENCY + 2);
        end

        // Reset while a store to 0x40 is in flight.
        d = ~ref_mem[16];
        if (LATENCY == 0) ref_mem[16] = d;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = d;
        req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_valid", resp_valid, 1'b0);
        check_eq("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0);

        for (int i = 0; i < 200; i++) begin
            a = 32'(($urandom % WINDOW) * 4);
            if ($urandom_range(7) == 0) a = a + 32'(4 * DEPTH * $urandom_range(3, 1));
            if ($urandom_range(7) == 0) a = a + 32'($urandom_range(3, 1));
            do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(3));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(2)) @(posedge clk);
                #1;
            end
        end

        model_access(1'b0, 32'h0, 32'h0, 4'h0, junk, jerr);
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
